// File: rtl/phy_link_pkg.sv
// phy_link_pkg: link constants and transmitter state type shared by par_ser_tx and its ser_par receiver.
package phy_link_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_CHAR = 8'hBC;
  typedef enum logic {TX_SYNC, TX_ACTIVE} tx_state_e;
endpackage

// File: rtl/par_ser_tx_if.sv
// par_ser_tx_if: byte valid/ready handshake into the transmitter.
interface par_ser_tx_if;
  import phy_link_pkg::*;
  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  modport master (output data_in, valid_in, input ready_out);
  modport slave  (input data_in, valid_in, output ready_out);
endinterface

// File: rtl/par_ser_tx_hold.sv
// par_ser_tx_hold: one-entry valid/ready holding register feeding the serializer.
module par_ser_tx_hold
  import phy_link_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              take_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [BYTE_W-1:0] data_o
);
  logic              full_q, full_d, accept;
  logic [BYTE_W-1:0] data_q, data_d;
  always_comb begin
    ready_o = reset & (~full_q | take_i);
    accept  = valid_i & ready_o;
    full_d  = accept | (full_q & ~take_i);
    data_d  = accept ? data_i : data_q;
  end
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/par_ser_tx.sv
// par_ser_tx: MSB-first byte serializer with comma SYNC preamble; PAR_SER_TX_STATS_EN adds byte counters.
module par_ser_tx
  import phy_link_pkg::*;
#(
  parameter int SYNC_CHARS = 4
`ifdef PAR_SER_TX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk_32f,
  input  logic reset,
  par_ser_tx_if.slave link,
  output logic data_out,
  output logic byte_strb,
  output logic active,
  output logic is_data
`ifdef PAR_SER_TX_STATS_EN
  , output logic [CNT_W-1:0] tx_data_cnt
  , output logic [CNT_W-1:0] tx_idle_cnt
`endif
);
  localparam int SC_W = $clog2(SYNC_CHARS + 1);
  tx_state_e         state_q, state_d;
  logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] sh_q, sh_d, next_byte, hold_data;
  logic              data_out_q, data_out_d, strb_q, strb_d;
  logic              active_q, active_d, is_data_q, is_data_d;
  logic              boundary, take, send_data, hold_full;
  par_ser_tx_hold u_hold (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_i  (link.data_in),
    .valid_i (link.valid_in),
    .take_i  (take),
    .ready_o (link.ready_out),
    .full_o  (hold_full),
    .data_o  (hold_data)
  );
  always_comb begin
    boundary   = bit_cnt_q == 3'd7;
    take       = boundary & (state_q == TX_ACTIVE);
    send_data  = take & hold_full;
    next_byte  = send_data ? hold_data : COMMA_CHAR;
    sh_d       = boundary ? next_byte : sh_q << 1;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    state_d    = (boundary & (state_q == TX_SYNC) & (sync_cnt_q == SC_W'(1))) ? TX_ACTIVE : state_q;
    sync_cnt_d = (boundary & (state_q == TX_SYNC)) ? sync_cnt_q - SC_W'(1) : sync_cnt_q;
    // active follows the first load made in ACTIVE, one byte after the state change
    active_d   = active_q | take;
    is_data_d  = boundary ? send_data : is_data_q;
    data_out_d = sh_d[BYTE_W-1];
    strb_d     = boundary;
  end
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_SYNC;
      sync_cnt_q <= SC_W'(SYNC_CHARS);
      bit_cnt_q  <= 3'd7;
      sh_q       <= '0;
      data_out_q <= 1'b0;
      strb_q     <= 1'b0;
      active_q   <= 1'b0;
      is_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      data_out_q <= data_out_d;
      strb_q     <= strb_d;
      active_q   <= active_d;
      is_data_q  <= is_data_d;
    end
  end
  assign data_out  = data_out_q;
  assign byte_strb = strb_q;
  assign active    = active_q;
  assign is_data   = is_data_q;
`ifdef PAR_SER_TX_STATS_EN
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d, idle_cnt_q, idle_cnt_d;
  always_comb begin
    data_cnt_d = (boundary & send_data & ~&data_cnt_q) ? data_cnt_q + 1'b1 : data_cnt_q;
    idle_cnt_d = (boundary & ~send_data & ~&idle_cnt_q) ? idle_cnt_q + 1'b1 : idle_cnt_q;
  end
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      data_cnt_q <= data_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
  assign tx_data_cnt = data_cnt_q;
  assign tx_idle_cnt = idle_cnt_q;
`endif
endmodule

// File: tb/tb_par_ser_tx.sv
// tb_par_ser_tx: directed bench for par_ser_tx (SYNC preamble, single/back-to-back data, SYNC accept, mid-byte reset).
module tb_par_ser_tx;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  logic data_out, byte_strb, active, is_data;
  int   checks = 0;
  int   errors = 0;
  par_ser_tx_if link ();
`ifdef PAR_SER_TX_STATS_EN
  logic [3:0] tx_data_cnt, tx_idle_cnt;
  par_ser_tx #(.SYNC_CHARS(4), .CNT_W(4)) dut (
    .clk_32f(clk_32f), .reset(reset), .link(link), .data_out(data_out), .byte_strb(byte_strb),
    .active(active), .is_data(is_data), .tx_data_cnt(tx_data_cnt), .tx_idle_cnt(tx_idle_cnt));
`else
  par_ser_tx #(.SYNC_CHARS(4)) dut (
    .clk_32f(clk_32f), .reset(reset), .link(link), .data_out(data_out), .byte_strb(byte_strb),
    .active(active), .is_data(is_data));
`endif
  always #5 clk_32f = ~clk_32f;

  task automatic get_byte(output logic [7:0] b, output logic d, output logic a);
    int n;
    n = 0;
    b = '0;
    d = 1'b0;
    a = 1'b0;
    @(negedge clk_32f);
    while (!byte_strb && n < 20) begin
      @(negedge clk_32f);
      n++;
    end
    checks++;
    if (!byte_strb) begin
      errors++;
      $display("FAIL strobe_timeout got 0 exp 1");
      return;
    end
    d = is_data;
    a = active;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk_32f);
      b = {b[6:0], data_out};
    end
  endtask

  task automatic test_reset;
    link.valid_in = 1'b0;
    link.data_in  = 8'h00;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk_32f);
    checks++;
    if ({data_out, byte_strb, active, is_data, link.ready_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000", {data_out, byte_strb, active, is_data, link.ready_out});
    end
    link.valid_in = 1'b1;
    #1;
    checks++;
    if (link.ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0", link.ready_out);
    end
    link.valid_in = 1'b0;
    @(negedge clk_32f);
  endtask

  task automatic check_sync(input string tag);
    logic [7:0] b;
    logic d, a;
    for (int k = 0; k < 5; k++) begin
      get_byte(b, d, a);
      checks++;
      if (b !== 8'hBC || d !== 1'b0 || a !== (k == 4)) begin
        errors++;
        $display("FAIL %s_byte%0d got %h/%b/%b exp bc/0/%b", tag, k, b, d, a, k == 4);
      end
    end
  endtask

  task automatic test_sync;
    reset = 1'b1;
    check_sync("sync");
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic d, a;
    logic [7:0] exp_b [3] = '{8'hBC, 8'h5A, 8'hBC};
    checks++;
    if (link.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b exp 1", link.ready_out);
    end
    link.data_in  = 8'h5A;
    link.valid_in = 1'b1;
    @(posedge clk_32f);
    #1 link.valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      get_byte(b, d, a);
      checks++;
      if (b !== exp_b[k] || d !== (k == 1)) begin
        errors++;
        $display("FAIL single_byte%0d got %h/%b exp %h/%b", k, b, d, exp_b[k], k == 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v [3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] exp_b [5] = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'hBC};
    logic [7:0] got_b [5];
    logic       got_d [5];
    int         lows [3];
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          lows[i] = 0;
          link.data_in  = v[i];
          link.valid_in = 1'b1;
          while (!link.ready_out && lows[i] < 20) begin
            @(negedge clk_32f);
            lows[i]++;
          end
          @(negedge clk_32f);
        end
        link.valid_in = 1'b0;
      end
      begin
        logic a;
        for (int k = 0; k < 5; k++) get_byte(got_b[k], got_d[k], a);
      end
    join
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (lows[i] !== 7) begin
        errors++;
        $display("FAIL b2b_ready_low%0d got %0d exp 7", i, lows[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_b[k] !== exp_b[k] || got_d[k] !== (k >= 1 && k <= 3)) begin
        errors++;
        $display("FAIL b2b_byte%0d got %h/%b exp %h/%b", k, got_b[k], got_d[k], exp_b[k], k >= 1 && k <= 3);
      end
    end
  endtask

  task automatic test_sync_accept;
    logic [7:0] b;
    logic d, a;
    reset = 1'b0;
    repeat (2) @(negedge clk_32f);
    link.data_in  = 8'hA5;
    link.valid_in = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (link.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL syncacc_ready_pre got %b exp 1", link.ready_out);
    end
    @(posedge clk_32f);
    #1;
    checks++;
    if (link.ready_out !== 1'b0) begin
      errors++;
      $display("FAIL syncacc_ready_post got %b exp 0", link.ready_out);
    end
    link.valid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      get_byte(b, d, a);
      checks++;
      if (b !== (k == 4 ? 8'hA5 : 8'hBC) || d !== (k == 4) || a !== (k == 4)) begin
        errors++;
        $display("FAIL syncacc_byte%0d got %h/%b/%b exp %h/%b/%b", k, b, d, a, k == 4 ? 8'hA5 : 8'hBC, k == 4, k == 4);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    link.data_in  = 8'hFF;
    link.valid_in = 1'b1;
    @(posedge clk_32f);
    #1 link.valid_in = 1'b0;
    n = 0;
    @(negedge clk_32f);
    while (!(byte_strb && is_data) && n < 30) begin
      @(negedge clk_32f);
      n++;
    end
    repeat (3) @(negedge clk_32f);
    checks++;
    if (data_out !== 1'b1 || n >= 30) begin
      errors++;
      $display("FAIL midrst_bit3 got %b exp 1", data_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, byte_strb, active, is_data, link.ready_out} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs got %b exp 00000", {data_out, byte_strb, active, is_data, link.ready_out});
    end
    @(negedge clk_32f);
    reset = 1'b1;
    check_sync("midrst");
  endtask

`ifdef PAR_SER_TX_STATS_EN
  task automatic test_stats;
    logic [7:0] b;
    logic d, a;
    checks++;
    if (tx_idle_cnt !== 4'd5 || tx_data_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stats_idle5 got %0d/%0d exp 5/0", tx_idle_cnt, tx_data_cnt);
    end
    repeat (15) get_byte(b, d, a);
    checks++;
    if (tx_idle_cnt !== 4'd15 || tx_data_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stats_sat got %0d/%0d exp 15/0", tx_idle_cnt, tx_data_cnt);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sync();
    test_single();
    test_back_to_back();
    test_sync_accept();
    test_reset_mid();
`ifdef PAR_SER_TX_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
